// File: rtl/dpram_port_master.sv
// dpram_port_master
//   Initiator for one synchronous-read port of a dual-port RAM (1-cycle read
//   latency). Turns a valid/ready request stream of reads and writes into RAM
//   port cycles and returns read data, in request order, on a valid/ready
//   response stream backed by a credit-limited response FIFO.
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   req_valid/ready     request handshake; req_we selects write (1) / read (0)
//   req_addr, req_wdata request word address and write data
//   rsp_valid/ready     response handshake; rsp_rdata carries read data
//   ram_we, ram_addr,   combinational drive of the RAM port in the accept cycle
//   ram_din
//   ram_dout            RAM read data, valid one cycle after the read address
//
// Build option
//   DPRAM_PORT_MASTER_STATS_EN: adds rd_count/wr_count outputs counting accepted
//   reads and writes (wrapping 32-bit counters).
module dpram_port_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
`ifdef DPRAM_PORT_MASTER_STATS_EN
  ,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count
`endif
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [CW-1:0]         occ;
  logic                  accept, push, pop;

  // Every read in flight or parked in the FIFO holds one credit, so a push
  // can never land on a full FIFO unless a pop happens in the same cycle.
  assign occ       = count_q + CW'(rd_pend_q);
  assign req_ready = !rst && (occ < CW'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;

  // RAM port is driven straight from the request in the accept cycle; address
  // and data are parked at zero when idle.
  assign ram_we    = accept && req_we;
  assign ram_addr  = accept ? req_addr  : '0;
  assign ram_din   = accept ? req_wdata : '0;

  assign rsp_valid = !rst && (count_q != '0);
  assign rsp_rdata = rsp_valid ? fifo_q[rd_ptr_q] : '0;

  // ram_dout belongs to the read accepted one cycle earlier.
  assign push = rd_pend_q;
  assign pop  = rsp_valid && rsp_ready;

  always_comb begin
    rd_pend_d = accept && !req_we;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage is not reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= ram_dout;
  end

`ifdef DPRAM_PORT_MASTER_STATS_EN
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;

  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (accept && !req_we) rd_count_d = rd_count_q + 32'd1;
    if (accept &&  req_we) wr_count_d = wr_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule
